esp32_mdio_bridge: RTL and testbench

- Parametrised MDIO passthrough between the ESP32 (MAC side, drives MDC) and the LAN8720 (PHY side) with a live Clause-22 frame decoder.
- The decoder owns the bidirectional MDIO tristate direction, so PHY read data reaches the ESP32.
- It also captures each completed frame (op, PHY address, register, data) for LEDs and debug.
- Sits in the ESP32 RMII top level beside the RMII data passthru; MDC itself passes straight through.

---
 rtl/esp32_mdio_pkg.sv | 43 ++++
 rtl/esp32_sync_edge.sv | 41 ++++
 rtl/esp32_mdio_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_esp32_mdio_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/esp32_mdio_pkg.sv
//------------------------------------------------------------------------------
// Module   : esp32_mdio_pkg
// Brief    : Shared Clause-22 MDIO frame-decoder types and field constants.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package esp32_mdio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST2   = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        DATA  = 3'd6
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int LEN_OP    = 2;
    localparam int LEN_PHYAD = 5;
    localparam int LEN_REGAD = 5;
    localparam int LEN_TA    = 2;
    localparam int LEN_DATA  = 16;

    // Index of the final bit of the field currently being shifted in.
    function automatic logic [3:0] field_last(input mdio_state_t s);
        case (s)
            OP:      field_last = 4'(LEN_OP - 1);
            PHYAD:   field_last = 4'(LEN_PHYAD - 1);
            REGAD:   field_last = 4'(LEN_REGAD - 1);
            TA:      field_last = 4'(LEN_TA - 1);
            DATA:    field_last = 4'(LEN_DATA - 1);
            default: field_last = 4'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/esp32_sync_edge.sv
//------------------------------------------------------------------------------
// Module   : esp32_sync_edge
// Brief    : Multi-stage synchroniser for a trigger bit plus W data bits delayed
//            identically, with rise/fall pulses on the synchronised trigger.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module esp32_sync_edge #(
    parameter int C_SYNC = 2,
    parameter int W      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trig_in,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         rise,
    output logic         fall
);

    logic [C_SYNC-1:0][W:0] stage;
    logic                   trig_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= '0;
            trig_prev <= 1'b0;
        end else begin
            stage     <= {stage[C_SYNC-2:0], {trig_in, data_in}};
            trig_prev <= stage[C_SYNC-1][W];
        end
    end

    assign data_out = stage[C_SYNC-1][W-1:0];
    assign rise     =  stage[C_SYNC-1][W] & ~trig_prev;
    assign fall     = ~stage[C_SYNC-1][W] &  trig_prev;

endmodule

`default_nettype wire

// File: rtl/esp32_mdio_bridge.sv
//------------------------------------------------------------------------------
// Module   : esp32_mdio_bridge
// Brief    : ESP32 <-> LAN8720 MDIO passthrough with live Clause-22 decoder that
//            steers the tristate direction and captures completed frames.
//            Optional MDIO_LAST_READ_EN adds a PHY-0 last-read register table.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module esp32_mdio_bridge
    import esp32_mdio_pkg::*;
#(
    parameter int C_SYNC         = 2,
    parameter int C_PREAMBLE_MIN = 32,
    parameter int C_TIMEOUT_BITS = 12,
    parameter int C_CNT_BITS     = 16
) (
    input  logic                  clk_25mhz,
    input  logic                  rst_n,
    input  logic                  mdc_wifi,
    output logic                  mdc_phy,
    input  logic                  mdio_wifi_i,
    output logic                  mdio_wifi_o,
    output logic                  mdio_wifi_oe,
    input  logic                  mdio_phy_i,
    output logic                  mdio_phy_o,
    output logic                  mdio_phy_oe,
    output logic                  frame_valid,
    output logic                  frame_read,
    output logic [4:0]            frame_phyad,
    output logic [4:0]            frame_regad,
    output logic [15:0]           frame_data,
    output logic [C_CNT_BITS-1:0] frame_cnt,
    output logic [C_CNT_BITS-1:0] err_cnt
`ifdef MDIO_LAST_READ_EN
    ,
    output logic [15:0]           last_read_data,
    input  logic [4:0]            rd_regad,
    output logic [15:0]           rd_data
`endif
);

    localparam int               PRE_W   = $clog2(C_PREAMBLE_MIN + 1);
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(C_PREAMBLE_MIN);

    mdio_state_t                state;
    mdio_state_t                state_next;
    logic [1:0]                 mdio_s;
    logic                       mdc_rise;
    logic                       mdc_fall;
    logic                       sample_bit;
    logic                       last_bit;
    logic                       timeout;
    logic                       fsm_err;
    logic                       fsm_done;
    logic                       dir_set;
    logic                       st_start;
    logic [3:0]                 bit_cnt;
    logic [PRE_W-1:0]           pre_cnt;
    logic                       op_hi;
    logic                       op_read;
    logic [4:0]                 phyad_sh;
    logic [4:0]                 regad_sh;
    logic [15:0]                data_sh;
    logic [15:0]                frame_bits;
    logic                       dir;
    logic                       clr_pending;
    logic [C_TIMEOUT_BITS-1:0]  idle_timer;

    assign mdc_phy      = mdc_wifi;
    assign mdio_wifi_o  = mdio_phy_i;
    assign mdio_phy_o   = mdio_wifi_i;
    assign mdio_wifi_oe = dir;
    assign mdio_phy_oe  = ~dir;

    // MDIO bits ride through the same stages as MDC so the sample lines up
    // with the detected edge.
    esp32_sync_edge #(
        .C_SYNC (C_SYNC),
        .W      (2)
    ) u_sync (
        .clk      (clk_25mhz),
        .rst_n    (rst_n),
        .trig_in  (mdc_wifi),
        .data_in  ({mdio_phy_i, mdio_wifi_i}),
        .data_out (mdio_s),
        .rise     (mdc_rise),
        .fall     (mdc_fall)
    );

    assign sample_bit = dir ? mdio_s[1] : mdio_s[0];
    assign last_bit   = (bit_cnt == field_last(state));
    assign timeout    = (&idle_timer) && !(mdc_rise || mdc_fall);
    assign frame_bits = {data_sh[14:0], sample_bit};

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (fsm_err) begin
            state_next = IDLE;
        end else if (mdc_rise) begin
            case (state)
                IDLE:    if (st_start) state_next = ST2;
                ST2:     state_next = OP;
                OP:      if (last_bit) state_next = PHYAD;
                PHYAD:   if (last_bit) state_next = REGAD;
                REGAD:   if (last_bit) state_next = TA;
                TA:      if (last_bit) state_next = DATA;
                DATA:    if (last_bit) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // On reads the first TA bit is high-Z and ignored; the PHY must drive the
    // second one low or the frame is rejected.
    always_comb begin
        fsm_err  = 1'b0;
        fsm_done = 1'b0;
        dir_set  = 1'b0;
        st_start = 1'b0;
        if (timeout && state != IDLE) begin
            fsm_err = 1'b1;
        end else if (mdc_rise) begin
            case (state)
                IDLE:    st_start = !sample_bit && (pre_cnt >= PRE_MIN);
                ST2:     fsm_err  = !sample_bit;
                OP:      fsm_err  = last_bit && ({op_hi, sample_bit} != OP_READ)
                                             && ({op_hi, sample_bit} != OP_WRITE);
                REGAD:   dir_set  = last_bit && op_read;
                TA:      fsm_err  = last_bit && op_read && sample_bit;
                DATA:    fsm_done = last_bit;
                default: fsm_err  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            pre_cnt    <= '0;
            op_hi      <= 1'b0;
            op_read    <= 1'b0;
            phyad_sh   <= '0;
            regad_sh   <= '0;
            data_sh    <= '0;
            idle_timer <= '0;
        end else begin
            if (state_next != state) bit_cnt <= '0;
            else if (mdc_rise)       bit_cnt <= bit_cnt + 1'b1;

            if (state != IDLE || timeout) pre_cnt <= '0;
            else if (mdc_rise)            pre_cnt <= !sample_bit ? '0 :
                                                     (pre_cnt == PRE_MIN) ? pre_cnt : pre_cnt + 1'b1;

            if (mdc_rise) begin
                case (state)
                    OP: begin
                        op_hi   <= sample_bit;
                        op_read <= ({op_hi, sample_bit} == OP_READ);
                    end
                    PHYAD:   phyad_sh <= {phyad_sh[3:0], sample_bit};
                    REGAD:   regad_sh <= {regad_sh[3:0], sample_bit};
                    DATA:    data_sh  <= frame_bits;
                    default: ;
                endcase
            end

            if (mdc_rise || mdc_fall || timeout) idle_timer <= '0;
            else                                 idle_timer <= idle_timer + 1'b1;
        end
    end

    // Direction is released only on the MDC fall following the last data bit,
    // so the PHY keeps the ESP32 side driven through that final bit.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            dir         <= 1'b0;
            clr_pending <= 1'b0;
        end else if (fsm_err) begin
            dir         <= 1'b0;
            clr_pending <= 1'b0;
        end else if (dir_set) begin
            dir         <= 1'b1;
        end else if (fsm_done) begin
            clr_pending <= 1'b1;
        end else if (mdc_fall && clr_pending) begin
            dir         <= 1'b0;
            clr_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_read  <= 1'b0;
            frame_phyad <= '0;
            frame_regad <= '0;
            frame_data  <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            frame_valid <= fsm_done;
            if (fsm_done) begin
                frame_read  <= op_read;
                frame_phyad <= phyad_sh;
                frame_regad <= regad_sh;
                frame_data  <= frame_bits;
                frame_cnt   <= frame_cnt + 1'b1;
            end
            if (fsm_err) err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef MDIO_LAST_READ_EN
    logic [15:0] rd_table [32];

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rd_table[i] <= '0;
            last_read_data <= '0;
            rd_data        <= '0;
        end else begin
            rd_data <= rd_table[rd_regad];
            if (fsm_done && op_read) begin
                last_read_data <= frame_bits;
                if (phyad_sh == 5'd0) rd_table[regad_sh] <= frame_bits;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_esp32_mdio_bridge.sv
//------------------------------------------------------------------------------
// Module   : tb_esp32_mdio_bridge
// Brief    : Scoreboard bench for esp32_mdio_bridge with a register-file PHY model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_esp32_mdio_bridge;

    logic        clk_25mhz = 1'b0;
    logic        rst_n;
    logic        mdc_wifi;
    logic        mdc_phy;
    logic        mdio_wifi_i;
    logic        mdio_wifi_o;
    logic        mdio_wifi_oe;
    logic        mdio_phy_i;
    logic        mdio_phy_o;
    logic        mdio_phy_oe;
    logic        frame_valid;
    logic        frame_read;
    logic [4:0]  frame_phyad;
    logic [4:0]  frame_regad;
    logic [15:0] frame_data;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`ifdef MDIO_LAST_READ_EN
    logic [15:0] last_read_data;
    logic [4:0]  rd_regad;
    logic [15:0] rd_data;
    logic [15:0] last_rd0 [32];
`endif

    typedef struct packed {
        logic        rd;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] d;
        logic [15:0] fc;
        logic [15:0] ec;
    } exp_t;

    exp_t        sbq [$];
    logic [15:0] phy_mem [1024];
    logic [15:0] exp_frames;
    logic [15:0] exp_err;
    int          checks = 0;
    int          passes = 0;
    logic        fv_prev = 1'b0;

    esp32_mdio_bridge #(
        .C_SYNC         (2),
        .C_PREAMBLE_MIN (32),
        .C_TIMEOUT_BITS (12),
        .C_CNT_BITS     (16)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .rst_n        (rst_n),
        .mdc_wifi     (mdc_wifi),
        .mdc_phy      (mdc_phy),
        .mdio_wifi_i  (mdio_wifi_i),
        .mdio_wifi_o  (mdio_wifi_o),
        .mdio_wifi_oe (mdio_wifi_oe),
        .mdio_phy_i   (mdio_phy_i),
        .mdio_phy_o   (mdio_phy_o),
        .mdio_phy_oe  (mdio_phy_oe),
        .frame_valid  (frame_valid),
        .frame_read   (frame_read),
        .frame_phyad  (frame_phyad),
        .frame_regad  (frame_regad),
        .frame_data   (frame_data),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
`ifdef MDIO_LAST_READ_EN
        ,
        .last_read_data (last_read_data),
        .rd_regad       (rd_regad),
        .rd_data        (rd_data)
`endif
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a frame.
    always @(negedge clk_25mhz) begin
        exp_t e;
        check("oe_exclusive", 32'(mdio_wifi_oe ^ mdio_phy_oe), 32'd1);
        check("mdc_passthru", 32'(mdc_phy), 32'(mdc_wifi));
        if (frame_valid) begin
            check("frame_valid_single_pulse", 32'(fv_prev), 32'd0);
            check("frame_expected", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("frame_read",  32'(frame_read),  32'(e.rd));
                check("frame_phyad", 32'(frame_phyad), 32'(e.pa));
                check("frame_regad", 32'(frame_regad), 32'(e.ra));
                check("frame_data",  32'(frame_data),  32'(e.d));
                check("frame_cnt",   32'(frame_cnt),   32'(e.fc));
                check("err_cnt_at_frame", 32'(err_cnt), 32'(e.ec));
`ifdef MDIO_LAST_READ_EN
                if (e.rd) check("last_read_data", 32'(last_read_data), 32'(e.d));
`endif
            end
        end
        fv_prev = frame_valid;
    end

    // One MDC period (10 clocks); checks direction and passthrough at the end of the high phase.
    task automatic mdio_bit(input logic mac_b, input logic phy_b, input logic exp_dir);
        mdio_wifi_i = mac_b;
        mdio_phy_i  = phy_b;
        repeat (5) @(negedge clk_25mhz);
        mdc_wifi = 1'b1;
        repeat (5) @(negedge clk_25mhz);
        check("wifi_oe_dir", 32'(mdio_wifi_oe), 32'(exp_dir));
        check("wifi_o_follows_phy", 32'(mdio_wifi_o), 32'(mdio_phy_i));
        check("phy_o_follows_wifi", 32'(mdio_phy_o), 32'(mdio_wifi_i));
        mdc_wifi = 1'b0;
    endtask

    // Issues a frame; the expected capture is queued before the first bit goes out.
    task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] ra, input logic [15:0] wd, input int nbits);
        logic [31:0] bits;
        logic [15:0] rdat;
        logic        rd;
        logic        ok;
        rd   = (op == 2'b10);
        ok   = (pre >= 32) && (op == 2'b10 || op == 2'b01);
        rdat = phy_mem[{pa, ra}];
        bits = {2'b01, op, pa, ra, 2'b10, (rd ? rdat : wd)};
        if (ok && nbits == 32) begin
            exp_frames = exp_frames + 16'd1;
            sbq.push_back('{rd: rd, pa: pa, ra: ra, d: (rd ? rdat : wd), fc: exp_frames, ec: exp_err});
            if (!rd) phy_mem[{pa, ra}] = wd;
`ifdef MDIO_LAST_READ_EN
            if (rd && pa == 5'd0) last_rd0[ra] = rdat;
`endif
        end
        for (int i = 0; i < pre; i++) mdio_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (ok && rd && i >= 14)
                mdio_bit(1'b1, (i == 14) ? 1'b1 : bits[31-i], 1'b1);
            else
                mdio_bit(bits[31-i], bits[31-i], ok && rd && i >= 13);
        end
        if (nbits == 32) begin
            repeat (4) @(negedge clk_25mhz);
            check("dir_released_after_frame", 32'(mdio_phy_oe), 32'd1);
        end
    endtask

    initial begin
        #3_200_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        rst_n       = 1'b0;
        mdc_wifi    = 1'b0;
        mdio_wifi_i = 1'b1;
        mdio_phy_i  = 1'b1;
        exp_frames  = '0;
        exp_err     = '0;
        for (int i = 0; i < 1024; i++) phy_mem[i] = 16'($urandom);
`ifdef MDIO_LAST_READ_EN
        rd_regad = '0;
        for (int i = 0; i < 32; i++) last_rd0[i] = '0;
`endif
        repeat (5) @(negedge clk_25mhz);
        check("reset_phy_oe",      32'(mdio_phy_oe),  32'd1);
        check("reset_wifi_oe",     32'(mdio_wifi_oe), 32'd0);
        check("reset_frame_cnt",   32'(frame_cnt),    32'd0);
        check("reset_err_cnt",     32'(err_cnt),      32'd0);
        check("reset_frame_data",  32'(frame_data),   32'd0);
        check("reset_frame_valid", 32'(frame_valid),  32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_25mhz);

        send_frame(32, 2'b01, 5'd1, 5'd0, 16'h3100, 32);
        check("write_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        phy_mem[{5'd1, 5'd2}] = 16'h0007;
        send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 32);

        send_frame(20, 2'b01, 5'd3, 5'd4, 16'h1234, 32);
        check("short_pre_err_cnt",   32'(err_cnt),   32'(exp_err));
        check("short_pre_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        send_frame(32, 2'b11, 5'd0, 5'd0, 16'h0000, 4);
        exp_err = exp_err + 16'd1;
        repeat (4) @(negedge clk_25mhz);
        check("bad_op_err_cnt", 32'(err_cnt),      32'(exp_err));
        check("bad_op_dir",     32'(mdio_wifi_oe), 32'd0);

        for (int n = 0; n < 14; n++) begin
            pa = 5'($urandom_range(0, 3));
            ra = 5'($urandom);
            wd = 16'($urandom);
            send_frame(int'($urandom_range(32, 40)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                       pa, ra, wd, 32);
        end
        check("random_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        send_frame(32, 2'b10, 5'd0, 5'd5, 16'h0000, 24);
        check("stall_dir_held", 32'(mdio_wifi_oe), 32'd1);
        repeat (4000) @(negedge clk_25mhz);
        check("stall_no_early_timeout", 32'(err_cnt), 32'(exp_err));
        repeat (200) @(negedge clk_25mhz);
        exp_err = exp_err + 16'd1;
        check("timeout_err_cnt", 32'(err_cnt),     32'(exp_err));
        check("timeout_phy_oe",  32'(mdio_phy_oe), 32'd1);

`ifdef MDIO_LAST_READ_EN
        for (int r = 0; r < 32; r += 5) begin
            rd_regad = 5'(r);
            repeat (2) @(negedge clk_25mhz);
            check("rd_table", 32'(rd_data), 32'(last_rd0[r]));
        end
`endif

        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 20);
        check("mid_read_dir", 32'(mdio_wifi_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_phy_oe",    32'(mdio_phy_oe),  32'd1);
        check("async_reset_wifi_oe",   32'(mdio_wifi_oe), 32'd0);
        check("async_reset_frame_cnt", 32'(frame_cnt),    32'd0);
        check("async_reset_err_cnt",   32'(err_cnt),      32'd0);
        exp_frames = '0;
        exp_err    = '0;
`ifdef MDIO_LAST_READ_EN
        for (int i = 0; i < 32; i++) last_rd0[i] = '0;
`endif
        mdio_wifi_i = 1'b1;
        mdio_phy_i  = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        send_frame(32, 2'b01, 5'd2, 5'd9, 16'hA55A, 32);
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);
        check("post_reset_err_cnt",   32'(err_cnt),   32'd0);

        repeat (10) @(negedge clk_25mhz);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
